// File: rtl/seg_pkg.sv
// Purpose : shared constants and helpers for the multiplexed 7-segment driver.
// Latency : n/a (package: constants and pure functions only).
// Backpr. : n/a.
// Contents: segment bit indices, 16-entry hex font, font lookup, inactive-level helper.
package seg_pkg;

   // Bit positions inside a segment byte {dp,g,f,e,d,c,b,a}.
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Hex font, gfedcba, index = nibble value.
   localparam logic [6:0] HEX_FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] font_lookup(input logic [3:0] nib);
      return HEX_FONT[nib];
   endfunction

   // Idle level of the segment pins for a given polarity.
   function automatic logic [7:0] seg_inactive(input bit act_low);
      return act_low ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Purpose : combinational nibble to 7-segment (gfedcba) font ROM.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; no flow control.
// Ports   : nib_dat (4b nibble in), font_dat (7b gfedcba out).
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib_dat,
   output logic [6:0] font_dat
);

   assign font_dat = font_lookup(nib_dat);

endmodule

// File: rtl/seg_mux_n.sv
// Purpose : N-digit time-multiplexed 7-segment driver, double-buffered, PWM dimmed.
// Latency : seg/sel registered, 1 cycle after (cnt, dig, active); frame_done 1 cycle after the boundary.
// Backpr. : none; load is always accepted, last write before a frame boundary wins.
// Ports   : clk/rst (sync active-high); load+data/mode/blank fill the pending buffer;
//           brightness live duty; seg[7:0], sel[DIGITS-1:0] pin drive; frame_done pulse.
module seg_mux_n
   import seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int DIV_W       = 14,
   parameter int BRIGHT_W    = 4,
   parameter int SEG_ACT_LOW = 0,
   parameter int SEL_ACT_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DIGITS*8-1:0]   data,
   input  logic                  mode,
   input  logic [DIGITS-1:0]     blank,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     sel,
   output logic                  frame_done
);

   localparam int                DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(DIGITS - 1);
   localparam logic [7:0]        SEG_OFF  = seg_inactive(SEG_ACT_LOW != 0);
   localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACT_LOW != 0) ? '1 : '0;

   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [DIG_W-1:0]    dig_q, dig_d;
   logic [DIGITS*8-1:0] act_dat_q, act_dat_d, pend_dat_q, pend_dat_d;
   logic                act_mode_q, act_mode_d, pend_mode_q, pend_mode_d;
   logic [DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
   logic                pend_v_q, pend_v_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic                frame_done_q, frame_done_d;

   logic                tick, fb;
   logic [7:0]          cur_byte;
   logic                cur_blank;
   logic [6:0]          hex_font;
   logic                duty_on, lit;
   logic [7:0]          pattern;

   // Prescaler and digit scan.
   always_comb begin
      tick  = &cnt_q;
      fb    = tick && (dig_q == DIG_LAST);
      cnt_d = cnt_q + 1'b1;
      dig_d = dig_q;
      if (tick) begin
         // Explicit wrap so non-power-of-two digit counts never reach unused codes.
         dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
      end
   end

   // Double buffer: active only changes on a frame boundary, so a frame
   // always comes from exactly one load.
   always_comb begin
      act_dat_d    = act_dat_q;
      act_mode_d   = act_mode_q;
      act_blank_d  = act_blank_q;
      pend_dat_d   = pend_dat_q;
      pend_mode_d  = pend_mode_q;
      pend_blank_d = pend_blank_q;
      pend_v_d     = pend_v_q;
      if (load && fb) begin
         // Boundary coincides with the load: bypass pending, show next frame.
         act_dat_d   = data;
         act_mode_d  = mode;
         act_blank_d = blank;
         pend_v_d    = 1'b0;
      end else if (load) begin
         pend_dat_d   = data;
         pend_mode_d  = mode;
         pend_blank_d = blank;
         pend_v_d     = 1'b1;
      end else if (fb && pend_v_q) begin
         act_dat_d   = pend_dat_q;
         act_mode_d  = pend_mode_q;
         act_blank_d = pend_blank_q;
         pend_v_d    = 1'b0;
      end
   end

   // Select the byte and blank bit of the digit currently being scanned.
   always_comb begin
      cur_byte  = 8'h00;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_q == DIG_W'(i)) begin
            cur_byte  = act_dat_q[i*8 +: 8];
            cur_blank = act_blank_q[i];
         end
      end
   end

   // Single decoder shared across digits, muxed by dig.
   seg_hex_decode u_hex (
      .nib_dat  (cur_byte[3:0]),
      .font_dat (hex_font)
   );

   // Output stage. seg and sel share the same lit term, so seg is always
   // idle whenever sel is idle.
   always_comb begin
      duty_on      = (cnt_q[DIV_W-1 -: BRIGHT_W] < brightness);
      lit          = duty_on && !cur_blank;
      pattern      = act_mode_q ? {cur_byte[SEG_DP], hex_font} : cur_byte;
      sel_d        = (lit ? (DIGITS'(1) << dig_q) : '0) ^ SEL_OFF;
      seg_d        = (lit ? pattern : 8'h00) ^ SEG_OFF;
      frame_done_d = fb;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         dig_q        <= '0;
         act_dat_q    <= '0;
         act_mode_q   <= 1'b0;
         act_blank_q  <= '0;
         pend_dat_q   <= '0;
         pend_mode_q  <= 1'b0;
         pend_blank_q <= '0;
         pend_v_q     <= 1'b0;
         seg_q        <= SEG_OFF;
         sel_q        <= SEL_OFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         dig_q        <= dig_d;
         act_dat_q    <= act_dat_d;
         act_mode_q   <= act_mode_d;
         act_blank_q  <= act_blank_d;
         pend_dat_q   <= pend_dat_d;
         pend_mode_q  <= pend_mode_d;
         pend_blank_q <= pend_blank_d;
         pend_v_q     <= pend_v_d;
         seg_q        <= seg_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign sel        = sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_mux_n.sv
// Purpose : self-checking bench for seg_mux_n (4-digit, active-low, 3-digit instances).
// Latency : n/a.
// Backpr. : n/a.
module tb_seg_mux_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: DIGITS=4, DIV_W=4, BRIGHT_W=2, active-high.
   logic        rst = 1'b1, load = 1'b0, mode = 1'b0;
   logic [31:0] data = '0;
   logic [3:0]  blank = '0;
   logic [1:0]  brightness = 2'd3;
   logic [7:0]  seg;
   logic [3:0]  sel;
   logic        fd;

   // Polarity instance: both outputs active-low.
   logic        rst_p = 1'b1, load_p = 1'b0, mode_p = 1'b0;
   logic [31:0] data_p = '0;
   logic [3:0]  blank_p = '0;
   logic [1:0]  br_p = 2'd3;
   logic [7:0]  seg_p;
   logic [3:0]  sel_p;
   logic        fd_p;

   // Odd instance: DIGITS=3.
   logic        rst_o = 1'b1, load_o = 1'b0, mode_o = 1'b0;
   logic [23:0] data_o = '0;
   logic [2:0]  blank_o = '0;
   logic [1:0]  br_o = 2'd3;
   logic [7:0]  seg_o;
   logic [2:0]  sel_o;
   logic        fd_o;

   seg_mux_n #(.DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .SEG_ACT_LOW(0), .SEL_ACT_LOW(0)) u_dut (
      .clk(clk), .rst(rst), .load(load), .data(data), .mode(mode), .blank(blank),
      .brightness(brightness), .seg(seg), .sel(sel), .frame_done(fd));

   seg_mux_n #(.DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)) u_pol (
      .clk(clk), .rst(rst_p), .load(load_p), .data(data_p), .mode(mode_p), .blank(blank_p),
      .brightness(br_p), .seg(seg_p), .sel(sel_p), .frame_done(fd_p));

   seg_mux_n #(.DIGITS(3), .DIV_W(4), .BRIGHT_W(2), .SEG_ACT_LOW(0), .SEL_ACT_LOW(0)) u_odd (
      .clk(clk), .rst(rst_o), .load(load_o), .data(data_o), .mode(mode_o), .blank(blank_o),
      .brightness(br_o), .seg(seg_o), .sel(sel_o), .frame_done(fd_o));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [6:0] ref_font(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Reference model of the main instance: time since reset gives slot and
   // digit by division; buffers follow the load/boundary rules directly.
   int          m_t = 0;
   bit          m_valid = 1'b0;
   logic [31:0] m_ad = '0, m_pd = '0;
   logic        m_am = 1'b0, m_pm = 1'b0, m_pv = 1'b0;
   logic [3:0]  m_ab = '0, m_pb = '0;
   logic [7:0]  e_seg = '0;
   logic [3:0]  e_sel = '0;
   logic        e_fd = 1'b0;

   initial begin : model
      int c, d;
      logic [7:0] b, pat;
      bit lt, fbm;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_t = 0; m_ad = '0; m_pd = '0; m_am = 0; m_pm = 0; m_pv = 0;
            m_ab = '0; m_pb = '0; e_seg = '0; e_sel = '0; e_fd = 0; m_valid = 1'b1;
         end else begin
            c     = m_t % 16;
            d     = (m_t / 16) % 4;
            lt    = ((c / 4) < int'(brightness)) && !m_ab[d];
            b     = m_ad[8*d +: 8];
            pat   = m_am ? {b[7], ref_font(b[3:0])} : b;
            e_sel = lt ? 4'(1 << d) : 4'h0;
            e_seg = lt ? pat : 8'h00;
            fbm   = (m_t % 64) == 63;
            e_fd  = fbm;
            if (load && fbm) begin
               m_ad = data; m_am = mode; m_ab = blank; m_pv = 0;
            end else if (load) begin
               m_pd = data; m_pm = mode; m_pb = blank; m_pv = 1;
            end else if (fbm && m_pv) begin
               m_ad = m_pd; m_am = m_pm; m_ab = m_pb; m_pv = 0;
            end
            m_t++;
         end
      end
   end

   initial begin : model_chk
      forever begin
         @(negedge clk);
         if (m_valid) chk("model", {seg, sel, fd}, {e_seg, e_sel, e_fd});
      end
   end

   task automatic wait_fd(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((which == 0 && fd) || (which == 1 && fd_p) || (which == 2 && fd_o)) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        mode;
      logic [3:0]  blank;
      logic [1:0]  bright;
      logic [31:0] exp_seg;   // byte d = seg seen while digit d is lit
      logic [15:0] exp_lit;   // nibble d = lit cycles of digit d per frame
   } vec_t;

   vec_t vecs [6];

   initial begin : main
      bit ok;
      int lit_cnt [4];
      logic [31:0] seen;
      int fd_bad, bad, wrong, litn, wraps;
      logic [2:0] prev;
      logic [7:0] exp_s;

      vecs[0] = '{32'h04030201, 1'b0, 4'b0000, 2'd3, 32'h04030201, 16'hCCCC};
      vecs[1] = '{32'h8F0A0900, 1'b1, 4'b0000, 2'd3, 32'hF1776F3F, 16'hCCCC};
      vecs[2] = '{32'h04030201, 1'b0, 4'b0100, 2'd0, 32'h00000000, 16'h0000};
      vecs[3] = '{32'h04030201, 1'b0, 4'b0100, 2'd1, 32'h04000201, 16'h4044};
      vecs[4] = '{32'h0B0C0D0E, 1'b1, 4'b0000, 2'd2, 32'h7C395E79, 16'h8888};
      vecs[5] = '{32'hFF00A55A, 1'b0, 4'b0000, 2'd3, 32'hFF00A55A, 16'hCCCC};

      repeat (3) @(negedge clk);
      chk("reset_main", {seg, sel, fd}, 13'h0);
      chk("reset_pol", {seg_p, sel_p, fd_p}, {8'hFF, 4'hF, 1'b0});
      rst = 1'b0;

      // Table-driven frames.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         data = vecs[i].data; mode = vecs[i].mode; blank = vecs[i].blank;
         brightness = vecs[i].bright; load = 1'b1;
         @(negedge clk);
         load = 1'b0;
         wait_fd(0, ok);
         chk($sformatf("vec%0d_fd_wait", i), ok, 1);
         for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
         seen = '0; fd_bad = 0;
         for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
               if (sel == 4'(1 << d)) begin
                  lit_cnt[d]++;
                  seen[8*d +: 8] = seg;
               end
            end
            if (fd != (k == 64)) fd_bad++;
         end
         for (int d = 0; d < 4; d++) begin
            chk($sformatf("vec%0d_lit_d%0d", i, d), lit_cnt[d], vecs[i].exp_lit[4*d +: 4]);
            if (vecs[i].exp_lit[4*d +: 4] != 0)
               chk($sformatf("vec%0d_seg_d%0d", i, d), seen[8*d +: 8], vecs[i].exp_seg[8*d +: 8]);
         end
         chk($sformatf("vec%0d_fd_period", i), fd_bad, 0);
      end

      // Tear-free: two loads mid-frame, only the last appears next frame.
      wait_fd(0, ok);
      chk("tear_fd_wait", ok, 1);
      repeat (20) @(negedge clk);
      data = 32'h11111111; mode = 1'b0; blank = '0; load = 1'b1;
      @(negedge clk); load = 1'b0;
      repeat (9) @(negedge clk);
      data = 32'h22222222; load = 1'b1;
      @(negedge clk); load = 1'b0;
      bad = 0; ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         if (sel != 0 && (seg == 8'h11 || seg == 8'h22)) bad++;
         @(negedge clk);
         ok = fd;
      end
      chk("tear_fd_wait2", ok, 1);
      chk("tear_cur_frame", bad, 0);
      wrong = 0; litn = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (sel != 0) begin litn++; if (seg != 8'h22) wrong++; end
         if (k == 63) begin data = 32'h33333333; load = 1'b1; end
      end
      load = 1'b0;
      chk("tear_next_wrong", wrong, 0);
      chk("tear_next_lit", litn, 48);
      chk("coinc_fd", fd, 1);
      wrong = 0; litn = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (sel != 0) begin litn++; if (seg != 8'h33) wrong++; end
      end
      chk("coinc_wrong", wrong, 0);
      chk("coinc_lit", litn, 48);

      // Randomized traffic, checked by the model every cycle.
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         load = ($urandom_range(0, 15) == 0);
         if (load) begin
            data = $urandom; mode = 1'($urandom_range(0, 1)); blank = 4'($urandom);
         end
         if ($urandom_range(0, 39) == 0) brightness = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 399) == 0);
      end
      @(negedge clk); rst = 1'b0; load = 1'b0;

      // Polarity and mid-frame reset.
      rst_p = 1'b0; data_p = 32'h01010101; load_p = 1'b1;
      @(negedge clk); load_p = 1'b0;
      wait_fd(1, ok);
      chk("pol_fd_wait", ok, 1);
      @(negedge clk);
      chk("pol_lit_d0", {seg_p, sel_p}, {8'hFE, 4'b1110});
      repeat (20) @(negedge clk);
      data_p = 32'h02020202; load_p = 1'b1;
      @(negedge clk); load_p = 1'b0; rst_p = 1'b1;
      @(negedge clk);
      chk("pol_reset", {seg_p, sel_p, fd_p}, {8'hFF, 4'hF, 1'b0});
      rst_p = 1'b0; fd_bad = 0;
      for (int k = 1; k <= 65; k++) begin
         @(negedge clk);
         if (k == 1)  chk("pol_restart_d0", {seg_p, sel_p}, {8'hFF, 4'b1110});
         if (k == 17) chk("pol_restart_d1", {seg_p, sel_p}, {8'hFF, 4'b1101});
         if (k == 65) chk("pol_pending_lost", {seg_p, sel_p}, {8'hFF, 4'b1110});
         if (k <= 64 && fd_p != (k == 64)) fd_bad++;
      end
      chk("pol_fd_period", fd_bad, 0);

      // Three-digit wrap.
      rst_o = 1'b0; data_o = 24'h030201; load_o = 1'b1;
      @(negedge clk); load_o = 1'b0;
      wait_fd(2, ok);
      chk("odd_fd_wait", ok, 1);
      fd_bad = 0; bad = 0; wraps = 0; prev = 3'b000;
      for (int k = 1; k <= 144; k++) begin
         @(negedge clk);
         if (fd_o != (k % 48 == 0)) fd_bad++;
         if (sel_o == 3'b000) begin
            if (seg_o != 8'h00) bad++;
         end else begin
            case (sel_o)
               3'b001:  exp_s = 8'h01;
               3'b010:  exp_s = 8'h02;
               3'b100:  exp_s = 8'h03;
               default: begin exp_s = 8'hXX; bad++; end
            endcase
            if (seg_o !== exp_s) bad++;
            if (prev != 3'b000 && sel_o != prev) begin
               if (sel_o != {prev[1:0], prev[2]}) bad++;
               if (prev == 3'b100 && sel_o == 3'b001) wraps++;
            end
            prev = sel_o;
         end
      end
      chk("odd_fd_period", fd_bad, 0);
      chk("odd_scan", bad, 0);
      chk("odd_wraps", wraps, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
